// File: rtl/mmc3_a12_pkg.sv
// Shared types and default parameters for the MMC3 A12 edge qualifier.
package mmc3_a12_pkg;

    typedef enum logic [1:0] {
        HIGH,
        LOW_WAIT,
        ARMED
    } a12_state_e;

    localparam int A12_SYNC_DEF   = 2;
    localparam int A12_GLITCH_DEF = 2;
    localparam int A12_LOWM2_DEF  = 3;

endpackage

// File: rtl/mmc3_a12_qual_sync_deglitch.sv
// Synchroniser plus hold-count deglitcher; lvl_nxt exposes the level the register
// takes at the next edge so the parent can register edge pulses in step with lvl.
module sync_deglitch #(
    parameter int STAGES = 2,
    parameter int HOLD   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic lvl_nxt
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              lvl_q, lvl_d;
    logic              smp;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        smp    = sync_q[STAGES-1];
        lvl_d  = lvl_q;
        cnt_d  = '0;
        // Any sample matching the current level restarts the hold count.
        if (smp != lvl_q) begin
            if (cnt_q == CW'(HOLD - 1)) begin
                lvl_d = smp;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
        end
    end

    assign lvl     = lvl_q;
    assign lvl_nxt = lvl_d;

endmodule

// File: rtl/mmc3_a12_qual.sv
// MMC3 A12 rise qualifier: passes a filtered A12 rise only after enough M2 falls
// of low time, counting the rises it suppresses.
module mmc3_a12_qual
    import mmc3_a12_pkg::*;
#(
    parameter int SYNC_STAGES = A12_SYNC_DEF,
    parameter int GLITCH_CYC  = A12_GLITCH_DEF,
    parameter int LOW_M2      = A12_LOWM2_DEF
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       ppu_a12,
    input  logic       cpu_m2,
    output logic       a12_lvl,
    output logic       a12_pe,
    output logic       a12_ne,
    output logic       armed,
    output logic [7:0] sup_cnt
);

    localparam int             LCW     = (LOW_M2 > 0) ? $clog2(LOW_M2 + 1) : 1;
    localparam logic [LCW-1:0] LOW_MAX = LCW'(LOW_M2);

    logic a12_lvl_w, a12_nxt, m2_lvl, m2_nxt;
    logic rise_evt, fall_evt, m2_ne;

    a12_state_e     state_q, state_d;
    logic [LCW-1:0] low_ctr_q, low_ctr_d;
    logic [7:0]     sup_cnt_q, sup_cnt_d;
    logic           a12_pe_q, a12_pe_d;
    logic           a12_ne_q, a12_ne_d;

    sync_deglitch #(.STAGES(SYNC_STAGES), .HOLD(GLITCH_CYC)) u_a12 (
        .clk     (clk),
        .rst     (map_rst),
        .din     (ppu_a12),
        .lvl     (a12_lvl_w),
        .lvl_nxt (a12_nxt)
    );

    sync_deglitch #(.STAGES(SYNC_STAGES), .HOLD(1)) u_m2 (
        .clk     (clk),
        .rst     (map_rst),
        .din     (cpu_m2),
        .lvl     (m2_lvl),
        .lvl_nxt (m2_nxt)
    );

    always_comb begin
        rise_evt  = a12_nxt & ~a12_lvl_w;
        fall_evt  = ~a12_nxt & a12_lvl_w;
        m2_ne     = m2_lvl & ~m2_nxt;
        state_d   = state_q;
        low_ctr_d = low_ctr_q;
        sup_cnt_d = sup_cnt_q;
        a12_pe_d  = 1'b0;
        a12_ne_d  = fall_evt;

        // A rise landing on the same cycle as an M2 fall takes priority over the credit.
        if (a12_lvl_w || rise_evt) begin
            low_ctr_d = '0;
        end else if (m2_ne && (low_ctr_q != LOW_MAX)) begin
            low_ctr_d = low_ctr_q + LCW'(1);
        end

        case (state_q)
            HIGH: begin
                if (fall_evt) begin
                    state_d = (LOW_M2 == 0) ? ARMED : LOW_WAIT;
                end
            end
            LOW_WAIT: begin
                if (rise_evt) begin
                    state_d = HIGH;
                    if (sup_cnt_q != 8'hFF) begin
                        sup_cnt_d = sup_cnt_q + 8'd1;
                    end
                end else if (low_ctr_q == LOW_MAX) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise_evt) begin
                    state_d  = HIGH;
                    a12_pe_d = 1'b1;
                end
            end
            default: state_d = LOW_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state_q   <= LOW_WAIT;
            low_ctr_q <= '0;
            sup_cnt_q <= '0;
            a12_pe_q  <= 1'b0;
            a12_ne_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            low_ctr_q <= low_ctr_d;
            sup_cnt_q <= sup_cnt_d;
            a12_pe_q  <= a12_pe_d;
            a12_ne_q  <= a12_ne_d;
        end
    end

    assign a12_lvl = a12_lvl_w;
    assign a12_pe  = a12_pe_q;
    assign a12_ne  = a12_ne_q;
    assign armed   = (state_q == ARMED);
    assign sup_cnt = sup_cnt_q;

endmodule

// File: tb/tb_mmc3_a12_qual.sv
// Directed bench for mmc3_a12_qual: default instance plus a LOW_M2=0 instance,
// with edge pulses checked against a queue of expected arrival cycles.
module tb_mmc3_a12_qual;

    logic       clk = 1'b0;
    logic       map_rst;
    logic       ppu_a12, cpu_m2, ppu2, m2_2;
    logic       a12_lvl, a12_pe, a12_ne, armed;
    logic       lvl2, pe2, ne2, armed2;
    logic [7:0] sup_cnt, sup2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_sup = 0;
    int pe2_cnt = 0;
    int ne2_cnt = 0;
    int pe_q[$], ne_q[$], pe2_q[$], ne2_q[$];

    mmc3_a12_qual dut (
        .clk(clk), .map_rst(map_rst), .ppu_a12(ppu_a12), .cpu_m2(cpu_m2),
        .a12_lvl(a12_lvl), .a12_pe(a12_pe), .a12_ne(a12_ne), .armed(armed), .sup_cnt(sup_cnt)
    );

    mmc3_a12_qual #(.LOW_M2(0)) dut0 (
        .clk(clk), .map_rst(map_rst), .ppu_a12(ppu2), .cpu_m2(m2_2),
        .a12_lvl(lvl2), .a12_pe(pe2), .a12_ne(ne2), .armed(armed2), .sup_cnt(sup2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m2_period();
        cpu_m2 = 1'b1;
        tick(4);
        cpu_m2 = 1'b0;
        tick(4);
    endtask

    // Pulse scoreboard: each observed pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        int e;
        if (a12_pe) begin
            chk("pe_pending", pe_q.size() > 0, 1);
            if (pe_q.size() > 0) begin e = pe_q.pop_front(); chk("pe_cycle", cyc, e); end
        end
        if (a12_ne) begin
            chk("ne_pending", ne_q.size() > 0, 1);
            if (ne_q.size() > 0) begin e = ne_q.pop_front(); chk("ne_cycle", cyc, e); end
        end
        if (pe2) begin
            pe2_cnt++;
            chk("pe2_pending", pe2_q.size() > 0, 1);
            if (pe2_q.size() > 0) begin e = pe2_q.pop_front(); chk("pe2_cycle", cyc, e); end
        end
        if (ne2) begin
            ne2_cnt++;
            chk("ne2_pending", ne2_q.size() > 0, 1);
            if (ne2_q.size() > 0) begin e = ne2_q.pop_front(); chk("ne2_cycle", cyc, e); end
        end
    end

    initial begin
        map_rst = 1'b1; ppu_a12 = 1'b0; cpu_m2 = 1'b0; ppu2 = 1'b0; m2_2 = 1'b0;
        tick(3);
        chk("rst_lvl", a12_lvl, 0);
        chk("rst_pe", a12_pe, 0);
        chk("rst_ne", a12_ne, 0);
        chk("rst_armed", armed, 0);
        chk("rst_sup", sup_cnt, 0);
        map_rst = 1'b0;
        tick(2);

        // Qualified rise after three M2 falls of low time
        m2_period();
        m2_period();
        chk("armed_after2", armed, 0);
        m2_period();
        tick(4);
        chk("armed_after3", armed, 1);
        ppu_a12 = 1'b1;
        pe_q.push_back(cyc + 4);
        tick(8);
        chk("q_lvl", a12_lvl, 1);
        chk("q_armed", armed, 0);
        chk("q_sup", sup_cnt, 0);

        // Short glitches while armed, then a 3-clk pulse
        ppu_a12 = 1'b0;
        ne_q.push_back(cyc + 4);
        tick(6);
        m2_period(); m2_period(); m2_period();
        tick(4);
        chk("g_armed_pre", armed, 1);
        for (int g = 0; g < 2; g++) begin
            ppu_a12 = 1'b1;
            tick(1);
            ppu_a12 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick(1);
                chk("g_lvl", a12_lvl, 0);
            end
        end
        chk("g_armed_post", armed, 1);
        ppu_a12 = 1'b1;
        pe_q.push_back(cyc + 4);
        tick(3);
        ppu_a12 = 1'b0;
        ne_q.push_back(cyc + 4);
        tick(8);
        chk("g3_lvl", a12_lvl, 0);
        chk("g3_armed", armed, 0);

        // Third M2 fall coincides with the filtered rise
        m2_period();
        m2_period();
        cpu_m2 = 1'b1;
        tick(4);
        ppu_a12 = 1'b1;
        tick(1);
        cpu_m2 = 1'b0;
        tick(8);
        exp_sup = exp_sup + 1;
        chk("co_sup", sup_cnt, exp_sup);
        chk("co_lvl", a12_lvl, 1);
        chk("co_armed", armed, 0);

        // Short low periods: suppressed, count saturates
        for (int n = 0; n < 300; n++) begin
            ppu_a12 = 1'b0;
            ne_q.push_back(cyc + 4);
            m2_period();
            m2_period();
            ppu_a12 = 1'b1;
            tick(8);
            if (exp_sup < 255) exp_sup = exp_sup + 1;
            chk("sat_sup", sup_cnt, exp_sup);
        end
        chk("sat_armed", armed, 0);

        // Reset while armed and low discards low time and count
        ppu_a12 = 1'b0;
        ne_q.push_back(cyc + 4);
        tick(6);
        m2_period(); m2_period(); m2_period();
        tick(4);
        chk("r_armed_pre", armed, 1);
        chk("r_lvl_pre", a12_lvl, 0);
        map_rst = 1'b1;
        tick(1);
        map_rst = 1'b0;
        chk("r_lvl", a12_lvl, 0);
        chk("r_pe", a12_pe, 0);
        chk("r_ne", a12_ne, 0);
        chk("r_armed", armed, 0);
        chk("r_sup", sup_cnt, 0);
        m2_period();
        tick(4);
        chk("r_armed_1m2", armed, 0);
        ppu_a12 = 1'b1;
        tick(8);
        chk("r_sup_after", sup_cnt, 1);
        chk("r_lvl_after", a12_lvl, 1);

        // LOW_M2=0 instance: every rise qualifies
        tick(2);
        chk("z_armed", armed2, 1);
        for (int k = 0; k < 8; k++) begin
            ppu2 = 1'b1;
            pe2_q.push_back(cyc + 4);
            tick(8);
            ppu2 = 1'b0;
            ne2_q.push_back(cyc + 4);
            tick(6);
            m2_2 = 1'b1;
            tick(4);
            m2_2 = 1'b0;
            tick(4);
        end
        tick(4);
        chk("z_pe_count", pe2_cnt, 8);
        chk("z_ne_count", ne2_cnt, 8);
        chk("z_sup", sup2, 0);
        chk("pe_q_left", pe_q.size(), 0);
        chk("ne_q_left", ne_q.size(), 0);
        chk("pe2_q_left", pe2_q.size(), 0);
        chk("ne2_q_left", ne2_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
